alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  N-bit handshaked ALU for the pico-mips datapath.
//  - Single-cycle ops: RA, RB, RADD, RSUB, RAND, ROR, RXOR. RMUL is multi-cycle (radix-2 Booth).
//  - Output is registered and carries ZF/NF/CF/VF flags.
//  - Valid/ready on both sides, so the controller can stall on multiplies and back-pressure results.
// PARAMETERS
//  N        8  operand/result width (>=4)
//  MUL_FRAC 1  1: RMUL returns fixed-point product[2N-2:N-1]; 0: integer low half product[N-1:0]
//  SAT      0  1: RADD/RSUB/RMUL saturate to 2^(N-1)-1 / -2^(N-1) on signed overflow; 0: wrap
// PORTS
//  clk        in   1  rising-edge clock
//  reset      in   1  synchronous, active-high reset
//  in_valid   in   1  operands/func valid
//  in_ready   out  1  block can accept an operation this cycle
//  a, b       in   N  signed operands
//  func       in   3  opcode per alucodes.sv (RA,RB,RADD,RSUB,RAND,ROR,RXOR,RMUL)
//  out_valid  out  1  result/flags valid
//  out_ready  in   1  consumer takes result this cycle
//  result     out  N  registered result
//  ZF,NF,CF,VF out 1  zero, negative, carry, signed-overflow flags of result
//  busy       out  1  multiplier iterating
// BEHAVIOUR
//  Reset:
//   - state=IDLE; out_valid=0; result=0; ZF=1; NF=CF=VF=0; busy=0.
//   - Any in-flight multiply is discarded.
//  Handshakes:
//   - Accept when in_valid && in_ready; operands and func are latched at the accept edge.
//   - in_ready = (state==IDLE) && (!out_valid || out_ready), i.e. accept and pop can occur in the same cycle.
//   - Result held stable (result and flags) while out_valid && !out_ready.
//   - out_valid drops after pop unless a new result is written on the same edge.
//  FSM:
//   - IDLE: on accept, a non-RMUL op writes the output regs at that edge; out_valid=1 next cycle.
//   - IDLE: on accept, RMUL loads a 2N-bit Booth accumulator and sets count=0 -> MUL; busy=1.
//   - MUL: one Booth step per cycle for N cycles.
//   - MUL: on count==N-1, write result/flags and set out_valid -> IDLE.
//   - The output is guaranteed empty at MUL exit (in_ready required it at accept).
//  Latency (accept edge to out_valid): 1 cycle for non-RMUL ops; N+1 cycles for RMUL. Throughput is 1 op per cycle for non-RMUL ops.
//  Arithmetic:
//   - RSUB = a + ~b + 1 using the shared adder.
//   - CF = unsigned carry-out of the N-bit add. For RSUB, CF=1 means no borrow.
//   - VF = signed overflow: add/sub operand-sign rule. For RMUL, VF=1 when the selected slice differs from the true signed value.
//   - MUL_FRAC=1: VF set only for (-2^(N-1))*(-2^(N-1)).
//   - SAT=1 replaces an overflowed result with the signed extreme of the true sign.
//  Flags for other ops:
//   - RA/RB/logic ops force CF=VF=0.
//   - ZF=(result==0) and NF=result[N-1] for all ops; both are evaluated after saturation.
//  Boundary conditions:
//   - in_valid with in_ready=0 is ignored; upstream holds.
//   - func is don't-care once latched.
//   - reset during MUL aborts the multiply with no output.
//   - Unknown func is impossible (3-bit, all 8 codes defined).
// TESTING (N=8)
//  1 RADD a=0x7F b=0x01, SAT=0 -> result 0x80, NF=1 VF=1 CF=0 ZF=0, out_valid 1 cycle after accept
//  2 RSUB a=0x05 b=0x05 -> 0x00 ZF=1 CF=1 VF=0; RSUB 0x00-0x01 -> 0xFF NF=1 CF=0
//  3 RMUL 0x40*0x40, MUL_FRAC=1 -> 0x20 after 9 cycles, busy high 8 cycles, in_ready low throughout
//  4 RMUL 0x80*0x80, MUL_FRAC=1 -> SAT=0: 0x80 VF=1; SAT=1: 0x7F VF=1
//  5 back-to-back RXOR 0xF0^0x0F with out_ready=0 for 3 cycles -> 0xFF held stable, in_ready=0; next op accepted on pop cycle
//  6 reset asserted 4 cycles into RMUL -> next cycle out_valid=0, in_ready=1, busy=0, result=0, ZF=1

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked N-bit ALU with registered result and flags.
// RMUL iterates a radix-2 Booth multiplier for N cycles.
module alu_pipe #(
  parameter int N        = 8,
  parameter bit MUL_FRAC = 1'b1,
  parameter bit SAT      = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   func,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ZF,
  output logic         NF,
  output logic         CF,
  output logic         VF,
  output logic         busy
);

  localparam logic [2:0] RA   = 3'd0;
  localparam logic [2:0] RB   = 3'd1;
  localparam logic [2:0] RADD = 3'd2;
  localparam logic [2:0] RSUB = 3'd3;
  localparam logic [2:0] RAND = 3'd4;
  localparam logic [2:0] ROR  = 3'd5;
  localparam logic [2:0] RXOR = 3'd6;
  localparam logic [2:0] RMUL = 3'd7;

  localparam int CW = $clog2(N);
  localparam int AW = 2 * N + 2;

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] count, count_nx;
  logic [AW-1:0] acc, acc_nx, acc_step;
  logic [N-1:0]  mcand, mcand_nx;
  logic [N:0]    mext, hi_sum;
  logic          mul_done;

  logic          accept;

  logic          sub;
  logic [N-1:0]  bb;
  logic [N:0]    sum;
  logic          add_ovf;
  logic [N-1:0]  alu_res;
  logic          alu_cf, alu_vf;

  logic [2*N-1:0] prod;
  logic [N-1:0]   mul_res;
  logic           mul_vf;

  logic          wr;
  logic [N-1:0]  wr_res;
  logic          wr_cf, wr_vf;

  assign busy     = (state == MUL);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Shared adder plus single-cycle op decode.
  always_comb begin
    sub     = (func == RSUB);
    bb      = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, sub};
    add_ovf = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    unique case (func)
      RA:   alu_res = a;
      RB:   alu_res = b;
      RADD,
      RSUB: begin
        alu_res = sum[N-1:0];
        alu_cf  = sum[N];
        alu_vf  = add_ovf;
        if (SAT && add_ovf)
          alu_res = a[N-1] ? MINV : MAXV;
      end
      RAND: alu_res = a & b;
      ROR:  alu_res = a | b;
      RXOR: alu_res = a ^ b;
      RMUL: alu_res = '0;
    endcase
  end

  // One Booth step: add/sub multiplicand on the high part, then shift.
  // High part has a guard bit so (-2^(N-1))^2 cannot wrap.
  always_comb begin
    mext   = {mcand[N-1], mcand};
    hi_sum = acc[AW-1:N+1];
    case (acc[1:0])
      2'b01:   hi_sum = acc[AW-1:N+1] + mext;
      2'b10:   hi_sum = acc[AW-1:N+1] - mext;
      default: hi_sum = acc[AW-1:N+1];
    endcase
    acc_step = {hi_sum[N], hi_sum, acc[N:1]};
  end

  // Product slice, overflow and optional saturation.
  always_comb begin
    prod = acc_step[2*N:1];
    if (MUL_FRAC) begin
      mul_res = prod[2*N-2:N-1];
      mul_vf  = prod[2*N-1] != prod[2*N-2];
    end else begin
      mul_res = prod[N-1:0];
      mul_vf  = prod[2*N-1:N-1] != {(N+1){prod[N-1]}};
    end
    if (SAT && mul_vf)
      mul_res = prod[2*N-1] ? MINV : MAXV;
  end

  // FSM next state and multiplier datapath.
  always_comb begin
    state_nx = state;
    count_nx = count;
    acc_nx   = acc;
    mcand_nx = mcand;
    mul_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && func == RMUL) begin
          acc_nx   = {{(N+1){1'b0}}, b, 1'b0};
          mcand_nx = a;
          count_nx = '0;
          state_nx = MUL;
        end
      end
      MUL: begin
        acc_nx   = acc_step;
        count_nx = count + 1'b1;
        if (count == LAST) begin
          mul_done = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  // FSM state and multiplier registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      mcand <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      acc   <= acc_nx;
      mcand <= mcand_nx;
    end
  end

  // Select which source writes the output register.
  always_comb begin
    wr     = mul_done || (accept && func != RMUL);
    wr_res = mul_done ? mul_res : alu_res;
    wr_cf  = mul_done ? 1'b0 : alu_cf;
    wr_vf  = mul_done ? mul_vf : alu_vf;
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      ZF        <= 1'b1;
      NF        <= 1'b0;
      CF        <= 1'b0;
      VF        <= 1'b0;
    end else begin
      out_valid <= wr || (out_valid && !out_ready);
      if (wr) begin
        result <= wr_res;
        ZF     <= (wr_res == '0);
        NF     <= wr_res[N-1];
        CF     <= wr_cf;
        VF     <= wr_vf;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe, three configurations
// (frac/wrap, frac/sat, integer/wrap) driven by shared stimulus.
module tb_alu_pipe;

  localparam logic [2:0] RA   = 3'd0;
  localparam logic [2:0] RB   = 3'd1;
  localparam logic [2:0] RADD = 3'd2;
  localparam logic [2:0] RSUB = 3'd3;
  localparam logic [2:0] RAND = 3'd4;
  localparam logic [2:0] ROR  = 3'd5;
  localparam logic [2:0] RXOR = 3'd6;
  localparam logic [2:0] RMUL = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a, b;
  logic [2:0] func;

  logic       rdy [3];
  logic       ov  [3];
  logic [7:0] res [3];
  logic       zf  [3];
  logic       nf  [3];
  logic       cf  [3];
  logic       vf  [3];
  logic       bsy [3];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [11:0] e0;
    logic [11:0] e1;
    logic [11:0] e2;
  } sb_t;

  sb_t q[$];

  always #5 clk = ~clk;

  alu_pipe #(.N(8), .MUL_FRAC(1'b1), .SAT(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .b(b), .func(func), .out_valid(ov[0]), .out_ready(out_ready),
    .result(res[0]), .ZF(zf[0]), .NF(nf[0]), .CF(cf[0]), .VF(vf[0]),
    .busy(bsy[0])
  );

  alu_pipe #(.N(8), .MUL_FRAC(1'b1), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a), .b(b), .func(func), .out_valid(ov[1]), .out_ready(out_ready),
    .result(res[1]), .ZF(zf[1]), .NF(nf[1]), .CF(cf[1]), .VF(vf[1]),
    .busy(bsy[1])
  );

  alu_pipe #(.N(8), .MUL_FRAC(1'b0), .SAT(1'b0)) u_int (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a), .b(b), .func(func), .out_valid(ov[2]), .out_ready(out_ready),
    .result(res[2]), .ZF(zf[2]), .NF(nf[2]), .CF(cf[2]), .VF(vf[2]),
    .busy(bsy[2])
  );

  // Reference: {result, Z, N, C, V} from signed integer arithmetic.
  function automatic logic [11:0] model(input logic [2:0] f,
                                        input logic [7:0] x,
                                        input logic [7:0] y,
                                        input bit frac,
                                        input bit sat);
    int sx, sy, t, v_q;
    logic [7:0] r;
    bit c, v, ar;
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    c   = 1'b0;
    v   = 1'b0;
    ar  = 1'b0;
    v_q = 0;
    r   = 8'h00;
    case (f)
      RA:   r = x;
      RB:   r = y;
      RAND: r = x & y;
      ROR:  r = x | y;
      RXOR: r = x ^ y;
      RADD: begin
        v_q = sx + sy;
        c   = (int'(x) + int'(y)) > 255;
        ar  = 1'b1;
      end
      RSUB: begin
        v_q = sx - sy;
        c   = x >= y;
        ar  = 1'b1;
      end
      default: begin
        t   = sx * sy;
        v_q = frac ? (t >>> 7) : t;
        ar  = 1'b1;
      end
    endcase
    if (ar) begin
      v = (v_q > 127) || (v_q < -128);
      r = v_q[7:0];
      if (sat && v)
        r = (v_q < 0) ? 8'h80 : 8'h7F;
    end
    return {r, r == 8'h00, r[7], c, v};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Record the expected response at each accept.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else if (in_valid && rdy[0]) begin
      q.push_back('{model(func, a, b, 1'b1, 1'b0),
                    model(func, a, b, 1'b1, 1'b1),
                    model(func, a, b, 1'b0, 1'b0)});
    end
  end

  // Compare whenever a result is popped.
  always @(negedge clk) begin
    sb_t e;
    if (!reset && ov[0] && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'(res[0]), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("sb_wrap", 32'({res[0], zf[0], nf[0], cf[0], vf[0]}), 32'(e.e0));
        chk("sb_sat",  32'({res[1], zf[1], nf[1], cf[1], vf[1]}), 32'(e.e1));
        chk("sb_int",  32'({res[2], zf[2], nf[2], cf[2], vf[2]}), 32'(e.e2));
        chk("sb_valid_sat", 32'(ov[1]), 32'd1);
        chk("sb_valid_int", 32'(ov[2]), 32'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and return just after the edge that accepts it.
  task automatic send(input logic [2:0] f, input logic [7:0] x,
                      input logic [7:0] y);
    int n;
    func     = f;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    n        = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[0] && n < 50);
    if (!rdy[0])
      chk("send_timeout", 32'(rdy[0]), 32'd1);
    step();
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] v;
    case ($urandom_range(0, 5))
      0:       v = 8'h00;
      1:       v = 8'h7F;
      2:       v = 8'h80;
      3:       v = 8'hFF;
      4:       v = 8'h01;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int cyc, busy_n, bad;
    bit took;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 8'h00;
    b         = 8'h00;
    func      = RA;
    repeat (3) step();

    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_result", 32'(res[0]), 32'd0);
    chk("rst_zf", 32'(zf[0]), 32'd1);
    chk("rst_ncv", 32'({nf[0], cf[0], vf[0]}), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    reset = 1'b0;
    step();
    chk("rst_in_ready", 32'(rdy[0]), 32'd1);

    send(RADD, 8'h7F, 8'h01);
    in_valid = 1'b0;
    chk("t1_latency", 32'(ov[0]), 32'd1);
    chk("t1_result", 32'({res[0], zf[0], nf[0], cf[0], vf[0]}),
        32'({8'h80, 4'b0101}));
    step();

    send(RSUB, 8'h05, 8'h05);
    send(RSUB, 8'h00, 8'h01);
    in_valid = 1'b0;
    repeat (2) step();

    send(RMUL, 8'h40, 8'h40);
    in_valid = 1'b0;
    cyc    = 0;
    busy_n = 0;
    bad    = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (ov[0])
        break;
      if (bsy[0])
        busy_n++;
      if (rdy[0])
        bad++;
    end
    chk("t3_latency", 32'(cyc), 32'd9);
    chk("t3_busy_cycles", 32'(busy_n), 32'd8);
    chk("t3_in_ready_low", 32'(bad), 32'd0);
    chk("t3_busy_done", 32'(bsy[0]), 32'd0);
    chk("t3_result", 32'(res[0]), 32'h20);
    step();

    send(RMUL, 8'h80, 8'h80);
    in_valid = 1'b0;
    repeat (12) step();

    out_ready = 1'b0;
    send(RXOR, 8'hF0, 8'h0F);
    a = 8'h3C;
    b = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_in_ready_stall", 32'(rdy[0]), 32'd0);
      chk("t5_hold_valid", 32'(ov[0]), 32'd1);
      chk("t5_hold_result", 32'(res[0]), 32'hFF);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_accept_on_pop", 32'(rdy[0]), 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_second_result", 32'(res[0]), 32'h33);
    step();

    send(RMUL, 8'h33, 8'hC5);
    in_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    chk("t6_out_valid", 32'(ov[0]), 32'd0);
    chk("t6_in_ready", 32'(rdy[0]), 32'd1);
    chk("t6_busy", 32'(bsy[0]), 32'd0);
    chk("t6_result", 32'(res[0]), 32'd0);
    chk("t6_zf", 32'(zf[0]), 32'd1);
    reset = 1'b0;
    repeat (12) step();
    chk("t6_no_output", 32'(ov[0]), 32'd0);

    for (int it = 0; it < 600; it++) begin
      @(negedge clk);
      took = in_valid && rdy[0];
      step();
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        func     = 3'($urandom);
        a        = pick();
        b        = pick();
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    took = in_valid && rdy[0];
    step();
    if (!took) begin
      cyc = 0;
      while (!took && cyc < 50) begin
        @(negedge clk);
        took = rdy[0];
        cyc++;
        step();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
